// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the memory access unit.
// The unit uses the slave modport; the pipeline and memory side uses master.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [31:0]           resp_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_error, resp_rdata,
           mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_error, resp_rdata,
           mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores via
// read-modify-write, loads sign/zero-extended. All outputs are flops.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MEM_BYTES  = 128
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_e;

  function automatic logic [ADDR_WIDTH-1:0] nbytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return ADDR_WIDTH'(1);
      SZ_HALF: return ADDR_WIDTH'(2);
      default: return ADDR_WIDTH'(4);
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {{24{~uns & d[7]}}, d[7:0]};
      SZ_HALF: return {{16{~uns & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_error_q, resp_error_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [31:0]           mem_write_data_q, mem_write_data_d;

  logic                  bad_c;

  // Bounds check stays in ADDR_WIDTH bits; MEM_BYTES >= 4 so the limit cannot wrap
  assign bad_c = (bus.req_size == SZ_ILL) ||
                 (bus.req_addr > (ADDR_WIDTH'(MEM_BYTES) - nbytes(bus.req_size)));

  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    uns_d            = uns_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    resp_error_d     = 1'b0;
    resp_rdata_d     = 32'h0;
    mem_write_data_d = 32'h0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata[15:0];
          if (bad_c) begin
            state_d      = RESP;
            resp_error_d = 1'b1;
          end else if (!bus.req_write) begin
            state_d = READ;
          end else if (bus.req_size == SZ_WORD) begin
            state_d          = WRITE;
            mem_write_data_d = bus.req_wdata;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      READ: begin
        state_d      = RESP;
        resp_rdata_d = extend(size_q, uns_q, bus.mem_read_data);
      end
      RMW_READ: begin
        // Merge the new low bytes into the old word captured this edge
        state_d          = WRITE;
        mem_write_data_d = (size_q == SZ_BYTE) ?
                           {bus.mem_read_data[31:8], wdata_q[7:0]} :
                           {bus.mem_read_data[31:16], wdata_q};
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d   = (state_d == IDLE);
    resp_valid_d  = (state_d == RESP);
    mem_read_d    = (state_d == READ) || (state_d == RMW_READ);
    mem_write_d   = (state_d == WRITE);
    mem_address_d = (mem_read_d || mem_write_d) ? addr_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      size_q           <= 2'b00;
      uns_q            <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= 16'h0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= 32'h0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      size_q           <= size_d;
      uns_q            <= uns_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_error_q     <= resp_error_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array data memory model.
module tb_mem_access_unit;
  localparam int unsigned AW = 64;
  localparam int MB = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();
  mem_access_unit #(.ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem     [MB] = '{default: 8'h00};
  logic [7:0] ref_mem [MB] = '{default: 8'h00};

  typedef struct { logic err; logic [31:0] rdata; int lat; int acc; } exp_t;
  typedef struct { int addr; logic [31:0] data; } wexp_t;
  exp_t  sbq[$];
  wexp_t wq[$];

  int n_cmp = 0, n_err = 0, cyc = 0, n_resp = 0, n_strobe = 0, last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Combinational little-endian read; bytes past the end read as zero
  always_comb begin
    bus.mem_read_data = 32'h0;
    for (int i = 0; i < 4; i++)
      if (bus.mem_address + AW'(i) < AW'(MB))
        bus.mem_read_data[8*i +: 8] = mem[int'(bus.mem_address) + i];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_write)
      for (int i = 0; i < 4; i++)
        if (bus.mem_address + AW'(i) < AW'(MB))
          mem[int'(bus.mem_address) + i] <= bus.mem_write_data[8*i +: 8];
  end

  always @(negedge clk) begin : mon
    exp_t  e;
    wexp_t w;
    if (!rst) begin
      if (bus.mem_read || bus.mem_write) begin
        n_strobe++;
        chk("strobe_excl", 64'(bus.mem_read & bus.mem_write), 64'd0);
      end
      if (bus.mem_write) begin
        if (wq.size() == 0) chk("write_unexpected", 64'd1, 64'd0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", bus.mem_address, 64'(w.addr));
          chk("wr_data", 64'(bus.mem_write_data), 64'(w.data));
        end
      end
      if (bus.resp_valid) begin
        n_resp++;
        if (sbq.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
        else begin
          e = sbq.pop_front();
          chk("resp_error", 64'(bus.resp_error), 64'(e.err));
          chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
          chk("resp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
        end
      end
    end
  end

  function automatic logic [31:0] ref_word(input int a);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++)
      if (a + i < MB) w[8*i +: 8] = ref_mem[a + i];
    return w;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [1:0] sz, input logic uns, input logic [31:0] d);
    logic [31:0] r;
    if (sz == 2'b00)      r = {24'h0, d[7:0]};
    else if (sz == 2'b01) r = {16'h0, d[15:0]};
    else                  r = d;
    if (!uns && sz == 2'b00 && d[7])  r[31:8]  = 24'hFFFFFF;
    if (!uns && sz == 2'b01 && d[15]) r[31:16] = 16'hFFFF;
    return r;
  endfunction

  // Called at a negedge; returns at a negedge after the request is accepted
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input int addr, input logic [31:0] wd, input bit keep);
    exp_t e;
    wexp_t w;
    int nb, budget;
    logic [31:0] old;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e.err = (sz == 2'b11) || (addr > MB - nb);
    e.rdata = 32'h0;
    old = ref_word(addr);
    w.addr = addr;
    w.data = 32'h0;
    if (e.err) e.lat = 1;
    else if (!wr) begin
      e.lat = 2;
      e.rdata = ref_ext(sz, uns, old);
    end else begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      w.data = (sz == 2'b10) ? wd : (sz == 2'b01) ? {old[31:16], wd[15:0]} : {old[31:8], wd[7:0]};
      for (int i = 0; i < 4; i++)
        if (addr + i < MB) ref_mem[addr + i] = w.data[8*i +: 8];
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = AW'(addr);
    bus.req_wdata = wd;
    budget = 0;
    while (!bus.req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc = cyc;
    last_acc = cyc;
    sbq.push_back(e);
    if (!e.err && wr) wq.push_back(w);
    if (!keep) bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int budget = 0;
    while ((sbq.size() != 0 || wq.size() != 0) && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (sbq.size() != 0 || wq.size() != 0) begin
      chk("resp_timeout", 64'(sbq.size() + wq.size()), 64'd0);
      sbq.delete();
      wq.delete();
    end
  endtask

  task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                     input int addr, input logic [31:0] wd);
    do_req(wr, sz, uns, addr, wd, 1'b0);
    wait_done();
  endtask

  initial begin
    int s0, r0, a1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_mem_address", bus.mem_address, 64'd0);
    chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store/load, then byte RMW onto 0x11223344
    txn(1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 'h10, 32'h0);
    txn(1'b1, 2'b10, 1'b0, 'h20, 32'h11223344);
    s0 = n_strobe;
    txn(1'b1, 2'b00, 1'b0, 'h20, 32'h000000AB);
    chk("rmw_strobes", 64'(n_strobe - s0), 64'd2);
    txn(1'b0, 2'b10, 1'b0, 'h20, 32'h0);

    // Load extension on 0x0000F080
    txn(1'b1, 2'b10, 1'b0, 'h30, 32'h0000F080);
    txn(1'b0, 2'b00, 1'b0, 'h30, 32'h0);
    txn(1'b0, 2'b00, 1'b1, 'h30, 32'h0);
    txn(1'b0, 2'b01, 1'b0, 'h30, 32'h0);
    txn(1'b0, 2'b01, 1'b1, 'h30, 32'h0);

    // Errors must not strobe memory; boundary accesses just inside are legal
    s0 = n_strobe;
    txn(1'b0, 2'b10, 1'b0, 125, 32'h0);
    txn(1'b0, 2'b11, 1'b0, 'h10, 32'h0);
    txn(1'b1, 2'b00, 1'b0, 200, 32'h55);
    txn(1'b0, 2'b01, 1'b0, 127, 32'h0);
    chk("err_no_strobe", 64'(n_strobe - s0), 64'd0);
    txn(1'b1, 2'b10, 1'b0, 124, 32'hCAFEF00D);
    txn(1'b0, 2'b00, 1'b0, 127, 32'h0);
    txn(1'b1, 2'b01, 1'b0, 'h31, 32'h00005A5A);
    txn(1'b0, 2'b10, 1'b0, 'h30, 32'h0);

    // Back-to-back loads with req_valid held
    r0 = n_resp;
    do_req(1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b1);
    a1 = last_acc;
    chk("busy_ready", 64'(bus.req_ready), 64'd0);
    do_req(1'b0, 2'b10, 1'b0, 'h20, 32'h0, 1'b0);
    chk("b2b_gap", 64'(last_acc - a1), 64'd3);
    wait_done();
    chk("b2b_resp_count", 64'(n_resp - r0), 64'd2);

    // Reset during RMW_READ: no write, no response
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = AW'('h20);
    bus.req_wdata = 32'h77;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read_strobe", 64'(bus.mem_read), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_mid_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mid_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    r0 = n_resp;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_resp", 64'(n_resp - r0), 64'd0);
    txn(1'b0, 2'b10, 1'b0, 'h20, 32'h0);

    // Random mix, including out-of-range and illegal sizes
    for (int k = 0; k < 24; k++)
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 131)), $urandom);

    chk("sb_empty", 64'(sbq.size() + wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
